aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//   Control FSM that drives the AES round counter: pulses ctr_start/advance, consumes round/is_final/done.
//   Issues per-round datapath operations (AddRoundKey, SubBytes+ShiftRows, MixColumns) over a valid/ack handshake.
//   Skips MixColumns on the final round. Presents block completion via out_valid/out_ready.
//   Sits between the top-level block request interface and the AES datapath.
// PARAMETERS
//   NR         10  rounds per block (10/12/14); checked against round when is_final is sampled
//   TIMEOUT_W  8   watchdog counter width (used only with AES_SEQ_TIMEOUT_EN)
// PORTS
//   clk          in   1  single clock; all state on rising edge
//   rst          in   1  synchronous, active-high reset
//   start_valid  in   1  block request
//   start_ready  out  1  high only in IDLE
//   ctr_start    out  1  one-cycle pulse; round counter loads round 0
//   advance      out  1  one-cycle pulse; round counter increments
//   round        in   4  current round from counter
//   is_final     in   1  counter: round == NR
//   done         in   1  counter: advanced past final round
//   op_valid     out  1  datapath op request
//   op_code      out  2  00 ARK, 01 SUB_SHIFT, 10 MIX, 11 reserved (never driven)
//   op_round     out  4  round tag for op (key-schedule index)
//   op_ack       in   1  datapath op complete
//   out_valid    out  1  block finished
//   out_ready    in   1  consumer accepts
//   busy         out  1  state != IDLE
//   err          out  1  sticky fault flag (tied 0 without macro)
// BEHAVIOUR
//   All outputs registered except start_ready/busy (decoded from state). Reset: state IDLE, all outputs 0
//   except start_ready=1. rst mid-block aborts immediately; no advance/op_valid pulse in the cycle after rst.
//   States: IDLE -> LOAD -> ARK0 -> ADV -> SUB -> [MIX] -> ARK -> ADV ... -> WAITDONE -> OUT -> IDLE
//   - IDLE: start_valid & start_ready accepts; next state LOAD.
//   - LOAD: ctr_start=1 for exactly one cycle; next ARK0.
//   - ARK0/SUB/MIX/ARK: op_valid=1, op_code/op_round held stable until op_ack sampled high.
//     op_round = round input latched on state entry. op_ack while op_valid=0 ignored.
//     op_valid drops the cycle after the ack; same-cycle ack is allowed (min 1 cycle per op).
//   - ADV: advance=1 for one cycle; next SUB, or WAITDONE if the previous ARK was at is_final.
//   - SUB -> MIX if !is_final; SUB -> ARK if is_final (MixColumns skipped).
//   - ARK: on ack, next ADV (final ARK also advances once, so counter raises done).
//   - WAITDONE: wait for done=1, then OUT.
//   - OUT: out_valid=1 until out_ready; back to IDLE next cycle. Back-pressure holds indefinitely.
//   Per block: NR+1 ARK, NR SUB, NR-1 MIX, NR+1 advance pulses, 1 ctr_start.
//   Zero-wait acks, NR=10: accept to out_valid = 1+1+30 ops+11 adv+1 waitdone = 44 cycles.
//   is_final sampled with round != NR: err set (both builds); sequencing continues per is_final.
//   start_valid outside IDLE ignored; no queuing.
// CONFIGURATION
//   AES_SEQ_TIMEOUT_EN defined:
//     - Watchdog counts cycles with op_valid=1 & !op_ack, or in WAITDONE.
//     - Reaching 2^TIMEOUT_W-1: op_valid drops, err=1, state -> IDLE. No out_valid.
//     - err cleared on next accepted start.
//   Undefined: no watchdog; FSM waits forever on op_ack/done; err only from the round-mismatch check.
// TESTING
//   1 Reset, then NR=10, ideal counter model, op_ack same-cycle -> op sequence ARK0,(SUB,MIX,ARK)x9,SUB,ARK;
//     11 advance pulses; out_valid at cycle 44.
//   2 op_ack delayed 3 cycles on every op -> op_code/op_round stable while op_valid=1; total 44+90 cycles.
//   3 out_ready low 5 cycles in OUT -> out_valid held; start_valid pulsed meanwhile is ignored;
//     start_ready=1 the cycle after handshake.
//   4 rst asserted during round 5 MIX -> next cycle op_valid=0, busy=0, start_ready=1;
//     new start completes normally.
//   5 Counter model raises is_final at round 7 -> err=1; MIX skipped at round 7.
//   6 (AES_SEQ_TIMEOUT_EN, TIMEOUT_W=4) op_ack never asserted -> op_valid drops after 15 cycles,
//     err=1, state IDLE; next start clears err.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer_if
// Purpose  : Bundles the request, round-counter, datapath-op and completion
//            handshakes of the AES round sequencer. The master modport is
//            the sequencer side; the slave modport is the environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_round_sequencer_if;
  logic       start_valid;
  logic       start_ready;
  logic       ctr_start;
  logic       advance;
  logic [3:0] round;
  logic       is_final;
  logic       done;
  logic       op_valid;
  logic [1:0] op_code;
  logic [3:0] op_round;
  logic       op_ack;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;

  modport master (
    input  start_valid, round, is_final, done, op_ack, out_ready,
    output start_ready, ctr_start, advance, op_valid, op_code, op_round,
           out_valid, busy, err
  );

  modport slave (
    output start_valid, round, is_final, done, op_ack, out_ready,
    input  start_ready, ctr_start, advance, op_valid, op_code, op_round,
           out_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Purpose  : Control FSM for one AES block: starts and steps the external
//            round counter and issues ARK / SUB_SHIFT / MIX operations to the
//            datapath, skipping MixColumns on the final round.
// Options  : AES_SEQ_TIMEOUT_EN - adds a watchdog that aborts a block stuck
//            on op_ack or done and clears err on the next accepted start.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
  parameter int NR        = 10,
  parameter int TIMEOUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_sequencer_if.master  bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_ARK0     = 4'd2;
  localparam logic [3:0] S_ADV      = 4'd3;
  localparam logic [3:0] S_SUB      = 4'd4;
  localparam logic [3:0] S_MIX      = 4'd5;
  localparam logic [3:0] S_ARK      = 4'd6;
  localparam logic [3:0] S_WAITDONE = 4'd7;
  localparam logic [3:0] S_OUT      = 4'd8;

  localparam logic [1:0] c_OP_ARK = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MIX = 2'b10;
  localparam logic [3:0] c_NR     = 4'(NR);

  logic [3:0] r_state;
  logic       r_ctr_start;
  logic       r_advance;
  logic       r_op_valid;
  logic [1:0] r_op_code;
  logic [3:0] r_rnd;
  logic       r_out_valid;
  logic       r_err;
  logic       r_last;

  logic [3:0] w_next;
  logic [1:0] w_op_code_next;
  logic       w_op_next;
  logic       w_op_done;
  logic       w_err_set;
  logic       w_err_clr;
  logic       w_timeout;

  assign w_op_done = r_op_valid && bus.op_ack;
  assign w_err_set = w_op_done && bus.is_final && (bus.round != c_NR) &&
                     ((r_state == S_SUB) || (r_state == S_ARK) || (r_state == S_ARK0));

`ifdef AES_SEQ_TIMEOUT_EN
  // Abort fires on the (2^TIMEOUT_W - 1)-th consecutive stalled cycle.
  localparam logic [TIMEOUT_W-1:0] c_WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 w_wd_count;

  assign w_wd_count = (r_op_valid && !bus.op_ack) || (r_state == S_WAITDONE);
  assign w_timeout  = w_wd_count && (r_wd == c_WD_LAST);
  assign w_err_clr  = (r_state == S_IDLE) && bus.start_valid;

  // Watchdog: counts stalled cycles, restarts whenever progress is made.
  always_ff @(posedge clk) begin
    if (rst || !w_wd_count || w_timeout) r_wd <= '0;
    else                                 r_wd <= r_wd + 1'b1;
  end
`else
  // No watchdog: the comparison is constant-false for any legal width.
  assign w_timeout = (TIMEOUT_W == 0);
  assign w_err_clr = 1'b0;
`endif

  // Next-state decode; sequencing decisions sample is_final at the op ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (bus.start_valid) w_next = S_LOAD;
      S_LOAD:        w_next = S_ARK0;
      S_ARK0, S_ARK: if (w_op_done) w_next = S_ADV;
      S_ADV:         w_next = r_last ? S_WAITDONE : S_SUB;
      S_SUB:         if (w_op_done) w_next = bus.is_final ? S_ARK : S_MIX;
      S_MIX:         if (w_op_done) w_next = S_ARK;
      S_WAITDONE:    if (bus.done) w_next = S_OUT;
      S_OUT:         if (bus.out_ready) w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Operation request implied by the state being entered.
  always_comb begin
    w_op_next      = 1'b0;
    w_op_code_next = r_op_code;
    case (w_next)
      S_ARK0, S_ARK: begin w_op_next = 1'b1; w_op_code_next = c_OP_ARK; end
      S_SUB:         begin w_op_next = 1'b1; w_op_code_next = c_OP_SUB; end
      S_MIX:         begin w_op_next = 1'b1; w_op_code_next = c_OP_MIX; end
      default:       ;
    endcase
  end

  // State and registered outputs; outputs reflect the state being entered.
  // r_rnd mirrors the counter: the counter loads/increments on the same edge
  // that moves us out of LOAD/ADV, so the raw round input would be one edge
  // stale at op entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ctr_start <= 1'b0;
      r_advance   <= 1'b0;
      r_op_valid  <= 1'b0;
      r_op_code   <= c_OP_ARK;
      r_rnd       <= 4'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ctr_start <= (w_next == S_LOAD);
      r_advance   <= (w_next == S_ADV);
      r_op_valid  <= w_op_next;
      r_op_code   <= w_op_code_next;
      r_out_valid <= (w_next == S_OUT);

      if (w_next == S_LOAD)     r_rnd <= 4'd0;
      else if (r_state == S_ADV) r_rnd <= r_rnd + 4'd1;

      if (w_next == S_LOAD)
        r_last <= 1'b0;
      else if (((r_state == S_ARK0) || (r_state == S_ARK)) && w_op_done)
        r_last <= bus.is_final;

      if (w_err_clr)                    r_err <= 1'b0;
      else if (w_err_set || w_timeout)  r_err <= 1'b1;
    end
  end

  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.ctr_start   = r_ctr_start;
  assign bus.advance     = r_advance;
  assign bus.op_valid    = r_op_valid;
  assign bus.op_code     = r_op_code;
  assign bus.op_round    = r_rnd;
  assign bus.out_valid   = r_out_valid;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Purpose  : Scoreboard bench for aes_round_sequencer: a round-counter model,
//            randomized op_ack / out_ready responders, and a monitor that
//            checks each datapath op and each completed block against
//            expectations computed from the round rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;
  localparam int NR = 10;
`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  typedef struct { logic [1:0] code; logic [3:0] rnd; } op_t;
  typedef struct { int nadv; bit err; int lat; } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sequencer_if bus();
  aes_round_sequencer #(.NR(NR), .TIMEOUT_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_checks = 0;
  int   n_errors = 0;
  op_t  opq[$];
  rec_t recq[$];
  int   dq[$];
  int   final_rnd = NR;
  int   hold_cnt = 0;
  bit   ack_never = 1'b0;
  bit   skip_mon = 1'b0;
  bit   model_err = 1'b0;
  int   blocks_done = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ideal round counter: load 0 on ctr_start, count on advance, done once
  // it advances past the final round.
  logic [3:0] c_round = 4'd0;
  logic       c_done  = 1'b0;
  always @(posedge clk) begin
    if (rst || bus.ctr_start) begin
      c_round <= 4'd0;
      c_done  <= 1'b0;
    end else if (bus.advance) begin
      if (c_round == 4'(final_rnd)) c_done <= 1'b1;
      c_round <= c_round + 4'd1;
    end
  end
  assign bus.round    = c_round;
  assign bus.is_final = (c_round == 4'(final_rnd)) && !c_done;
  assign bus.done     = c_done;

  always @(posedge clk) cyc++;

  // Datapath responder: each op waits its planned number of extra cycles.
  bit in_op = 1'b0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus.op_valid && !ack_never) begin
      if (!in_op) begin
        in_op = 1'b1;
        ack_cnt = 0;
        if (dq.size() > 0) ack_cnt = dq.pop_front();
      end
      if (ack_cnt == 0) begin
        bus.op_ack = 1'b1;
        in_op = 1'b0;
      end else begin
        ack_cnt--;
        bus.op_ack = 1'b0;
      end
    end else begin
      in_op = 1'b0;
      bus.op_ack = ack_never ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Consumer: withholds out_ready for hold_cnt cycles of out_valid.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid) begin
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end else begin
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard.
  bit   mb = 1'b0;
  int   adv_n = 0, ctr_n = 0, acc_cyc = 0, lat = 0;
  bit   seen_out = 1'b0;
  bit   p_opv = 1'b0, p_ack = 1'b0, p_outv = 1'b0, p_rdy = 1'b0;
  logic [1:0] p_code;
  logic [3:0] p_rnd;
  op_t  e_op;
  rec_t e_rec;
  always @(negedge clk) begin
    if (rst) begin
      mb = 1'b0; adv_n = 0; ctr_n = 0; seen_out = 1'b0;
      p_opv = 1'b0; p_ack = 1'b0; p_outv = 1'b0; p_rdy = 1'b0;
    end else begin
      if (skip_mon) begin
        mb = 1'b0;
      end else begin
        chk("busy", bus.busy, mb);
        chk("start_ready", bus.start_ready, !mb);
        if (p_opv && !p_ack)
          chk("op held stable", {bus.op_valid, bus.op_code, bus.op_round}, {1'b1, p_code, p_rnd});
        if (p_outv && !p_rdy)
          chk("out_valid held", bus.out_valid, 1'b1);
      end
      if (bus.op_valid && bus.op_ack) begin
        if (opq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected op: got code %0d round %0d, required none", bus.op_code, bus.op_round);
        end else begin
          e_op = opq.pop_front();
          chk("op code/round", {bus.op_code, bus.op_round}, {e_op.code, e_op.rnd});
        end
      end
      if (bus.advance)   adv_n++;
      if (bus.ctr_start) ctr_n++;
      if (bus.out_valid && !seen_out) begin
        seen_out = 1'b1;
        lat = cyc - acc_cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (recq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected block: got out handshake, required none");
        end else begin
          e_rec = recq.pop_front();
          chk("advance pulses", adv_n, e_rec.nadv);
          chk("ctr_start pulses", ctr_n, 1);
          chk("err at out", bus.err, e_rec.err);
          chk("latency", lat, e_rec.lat);
          chk("ops left", opq.size(), 0);
        end
        blocks_done++;
        seen_out = 1'b0;
        mb = 1'b0;
      end else if (!skip_mon && bus.start_valid && !mb) begin
        mb = 1'b1; acc_cyc = cyc; adv_n = 0; ctr_n = 0; seen_out = 1'b0;
      end
      p_opv = bus.op_valid; p_ack = bus.op_ack; p_code = bus.op_code; p_rnd = bus.op_round;
      p_outv = bus.out_valid; p_rdy = bus.out_ready;
    end
  end

  // Reference model: op list of a block whose counter finishes at round F.
  // mode < 0 draws a random ack delay per op, otherwise every op uses mode.
  task automatic prep_block(input int f, input int mode, input int hold);
    op_t  ops[$];
    rec_t r;
    int   d, sum;
    ops.push_back('{2'b00, 4'd0});
    for (int k = 1; k <= f; k++) begin
      ops.push_back('{2'b01, 4'(k)});
      if (k != f) ops.push_back('{2'b10, 4'(k)});
      ops.push_back('{2'b00, 4'(k)});
    end
    sum = 0;
    foreach (ops[i]) begin
      d = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
      dq.push_back(d);
      sum += 1 + d;
      opq.push_back(ops[i]);
    end
`ifdef AES_SEQ_TIMEOUT_EN
    model_err = (f != NR);
`else
    model_err = model_err | (f != NR);
`endif
    // accept + LOAD + ops + advances + WAITDONE
    r.nadv = f + 1;
    r.err  = model_err;
    r.lat  = 1 + 1 + sum + (f + 1) + 1;
    recq.push_back(r);
    final_rnd = f;
    hold_cnt  = hold;
  endtask

  task automatic start_block();
    int t;
    bus.start_valid = 1'b1;
    t = 0;
    while (!bus.start_ready && t < 200) begin
      @(posedge clk); #2; t++;
    end
    if (t >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL start accept: got start_ready=0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #2;
    bus.start_valid = 1'b0;
  endtask

  task automatic run_block(input int f, input int mode, input int hold);
    int t, target;
    prep_block(f, mode, hold);
    target = blocks_done + 1;
    start_block();
    t = 0;
    while (blocks_done < target && t < 5000) begin
      if (bus.out_valid && !bus.out_ready) bus.start_valid = 1'b1;
      else if (bus.op_valid)               bus.start_valid = 1'($urandom_range(0, 1));
      else                                 bus.start_valid = 1'b0;
      @(posedge clk); #2; t++;
    end
    bus.start_valid = 1'b0;
    chk("block completed", blocks_done, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opq.delete(); recq.delete(); dq.delete();
    model_err = 1'b0; hold_cnt = 0; bus.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset start_ready", bus.start_ready, 1'b1);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset op_valid", bus.op_valid, 1'b0);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset advance/ctr_start", {bus.advance, bus.ctr_start}, 2'b00);
    chk("reset err", bus.err, 1'b0);
  endtask

  initial begin
    int t, n;
    bus.start_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    run_block(NR, 0, 0);   // zero-wait acks
    run_block(NR, 3, 0);   // every ack three cycles late
    run_block(NR, 0, 5);   // consumer back-pressure with ignored start pulses

    // Reset in the middle of round 5 MixColumns.
    prep_block(NR, -1, 0);
    start_block();
    t = 0;
    while (!(bus.op_valid && bus.op_code == 2'b10 && bus.op_round == 4'd5) && t < 1000) begin
      @(posedge clk); #2; t++;
    end
    chk("reached round 5 MIX", {bus.op_valid, bus.op_code, bus.op_round}, {1'b1, 2'b10, 4'd5});
    rst = 1'b1;
    opq.delete(); recq.delete(); dq.delete(); model_err = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort op_valid", bus.op_valid, 1'b0);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort start_ready", bus.start_ready, 1'b1);
    chk("abort advance", bus.advance, 1'b0);
    run_block(NR, -1, 0);

    // Counter declares the final round early: err and no MIX at round 7.
    run_block(7, 0, 0);
    chk("err after early final", bus.err, 1'b1);

    do_reset();
    repeat (6) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : NR;
      run_block(n, -1, int'($urandom_range(0, 3)));
    end

`ifdef AES_SEQ_TIMEOUT_EN
    // Datapath never acknowledges: watchdog aborts the block.
    skip_mon = 1'b1;
    ack_never = 1'b1;
    final_rnd = NR;
    start_block();
    t = 0;
    while (!bus.op_valid && t < 50) begin
      @(negedge clk); t++;
    end
    n = 0;
    while (bus.op_valid && n < 100) begin
      n++; @(negedge clk);
    end
    chk("timeout op_valid cycles", n, (1 << TW) - 1);
    chk("timeout err", bus.err, 1'b1);
    chk("timeout busy", bus.busy, 1'b0);
    chk("timeout out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #2;
    ack_never = 1'b0;
    skip_mon = 1'b0;
    run_block(NR, 0, 0);
    chk("err cleared by start", bus.err, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
